// File: rtl/bg_scroll_renderer_if.sv
// ROM/palette side-bus of the scrolling background renderer.
// The renderer is the master: it drives the ROM address and the palette index.
interface bg_scroll_renderer_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned IDX_W  = 3
);
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q;
  logic [IDX_W-1:0]  pal_idx;
  logic [3:0]        pal_red;
  logic [3:0]        pal_green;
  logic [3:0]        pal_blue;

  modport master (
    output rom_addr, pal_idx,
    input  rom_q, pal_red, pal_green, pal_blue
  );

  modport slave (
    input  rom_addr, pal_idx,
    output rom_q, pal_red, pal_green, pal_blue
  );
endinterface

// File: rtl/bg_scroll_renderer.sv
// Scaled, scrolling, fading background renderer feeding the VGA colour mux.
// Pipeline: coordinate/address stage, external ROM (ROM_LAT), registered colour.
module bg_scroll_renderer #(
  parameter int unsigned SRC_W       = 320,
  parameter int unsigned SRC_H       = 240,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned ROM_LAT     = 1
) (
  input  logic                  vga_clk,
  input  logic                  reset,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic                  blank,
  input  logic                  frame_start,
  input  logic [9:0]            scroll_x_in,
  input  logic [9:0]            scroll_y_in,
  input  logic                  scroll_wen,
  input  logic                  fade_en,
  input  logic                  fade_dir,
  bg_scroll_renderer_if.master  mem,
  output logic [3:0]            red,
  output logic [3:0]            green,
  output logic [3:0]            blue,
  output logic [3:0]            fade_level
);

  localparam int unsigned CW    = 12;
  localparam int unsigned MAX_X = SRC_W << SCALE_SHIFT;
  localparam int unsigned MAX_Y = SRC_H << SCALE_SHIFT;

  logic [9:0]        shd_x_q, shd_x_d, shd_y_q, shd_y_d;
  logic [9:0]        act_x_q, act_x_d, act_y_q, act_y_d;
  logic [3:0]        fade_q, fade_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROM_LAT:0]  vld_q, vld_d;
  logic [3:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;

  logic [CW-1:0]     sx_sum, sy_sum, sx, sy;
  logic              wr_legal, in_range;

  function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? 4'(a - b) : 4'd0;
  endfunction

  // Scroll shadow/active registers and the per-frame fade step
  always_comb begin
    shd_x_d  = shd_x_q;
    shd_y_d  = shd_y_q;
    act_x_d  = act_x_q;
    act_y_d  = act_y_q;
    fade_d   = fade_q;
    wr_legal = (32'(scroll_x_in) < SRC_W) && (32'(scroll_y_in) < SRC_H);
    if (scroll_wen && wr_legal) begin
      shd_x_d = scroll_x_in;
      shd_y_d = scroll_y_in;
    end
    if (frame_start) begin
      act_x_d = shd_x_d;
      act_y_d = shd_y_d;
      if (fade_en) begin
        if (fade_dir) fade_d = (fade_q == 4'd15) ? 4'd15 : 4'(fade_q + 4'd1);
        else          fade_d = (fade_q == 4'd0)  ? 4'd0  : 4'(fade_q - 4'd1);
      end
    end
  end

  // Stage A: scaled source coordinates with a single wrap per axis
  always_comb begin
    sx_sum   = CW'(DrawX >> SCALE_SHIFT) + CW'(act_x_q);
    sy_sum   = CW'(DrawY >> SCALE_SHIFT) + CW'(act_y_q);
    sx       = (32'(sx_sum) >= SRC_W) ? CW'(32'(sx_sum) - SRC_W) : sx_sum;
    sy       = (32'(sy_sum) >= SRC_H) ? CW'(32'(sy_sum) - SRC_H) : sy_sum;
    addr_d   = ADDR_W'(32'(sy) * SRC_W + 32'(sx));
    in_range = (32'(DrawX) < MAX_X) && (32'(DrawY) < MAX_Y);
  end

  // Blank/range qualifier rides alongside the ROM latency so it lines up with rom_q
  always_comb begin
    vld_d = {vld_q[ROM_LAT-1:0], blank & in_range};
  end

  // Stage C: black outside active/in-range pixels, otherwise faded palette colour
  always_comb begin
    red_d   = 4'd0;
    green_d = 4'd0;
    blue_d  = 4'd0;
    if (vld_q[ROM_LAT]) begin
      red_d   = sat_sub(mem.pal_red,   fade_q);
      green_d = sat_sub(mem.pal_green, fade_q);
      blue_d  = sat_sub(mem.pal_blue,  fade_q);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      shd_x_q <= '0;
      shd_y_q <= '0;
      act_x_q <= '0;
      act_y_q <= '0;
      fade_q  <= '0;
      addr_q  <= '0;
      vld_q   <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      shd_x_q <= shd_x_d;
      shd_y_q <= shd_y_d;
      act_x_q <= act_x_d;
      act_y_q <= act_y_d;
      fade_q  <= fade_d;
      addr_q  <= addr_d;
      vld_q   <= vld_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign mem.rom_addr = addr_q;
  assign mem.pal_idx  = mem.rom_q;
  assign red          = red_q;
  assign green        = green_q;
  assign blue         = blue_q;
  assign fade_level   = fade_q;

endmodule

// File: doc/bg_scroll_renderer.md
Name: bg_scroll_renderer

Overview:
- Parametrised successor to the full-screen background renderer: maps VGA DrawX/DrawY onto a SRC_W x SRC_H indexed background ROM with power-of-two scaling.
- Adds frame-synchronous horizontal/vertical scroll with wrap-around, a per-frame fade-to-black engine and a fully pipelined, latency-matched blank path.
- The ROM and palette are external; this block drives the ROM address, receives the palette index, and registers the final RGB into the VGA output mux.

Parameters:
SRC_W, 320, source image width in pixels
SRC_H, 240, source image height in pixels
SCALE_SHIFT, 1, screen-to-source downscale as a shift (1 = 2x stretch, 0 = 1:1)
IDX_W, 3, palette index width
ADDR_W, 17, ROM address width; must satisfy 2^ADDR_W >= SRC_W*SRC_H
ROM_LAT, 1, ROM read latency in vga_clk cycles (1..4)

Ports:
vga_clk  in  1  pixel clock; all state on posedge
reset  in  1  synchronous, active-high reset
DrawX  in  10  current screen column
DrawY  in  10  current screen row
blank  in  1  1 = active video (display enable)
frame_start  in  1  one-cycle pulse at start of vertical blanking
scroll_x_in  in  10  requested horizontal scroll in source pixels
scroll_y_in  in  10  requested vertical scroll in source pixels
scroll_wen  in  1  writes scroll_x_in/scroll_y_in into the shadow registers
fade_en  in  1  enables the fade step at each frame_start
fade_dir  in  1  1 = fade toward black, 0 = fade back toward full colour
rom_addr  out  ADDR_W  registered ROM address
rom_q  in  IDX_W  ROM data, valid ROM_LAT cycles after rom_addr
pal_idx  out  IDX_W  palette index, equal to rom_q, to the combinational palette
pal_red/pal_green/pal_blue  in  4 each  palette colour for pal_idx
red/green/blue  out  4 each  registered pixel colour
fade_level  out  4  current fade level (status)

Behaviour:
- Reset values: rom_addr=0; red/green/blue=0; fade_level=0; shadow and active scroll = 0; blank pipeline cleared to 0.
- Stage A (1 cycle) computes the source coordinates and registers rom_addr:
  - sx = (DrawX >> SCALE_SHIFT) + act_scroll_x; if sx >= SRC_W, subtract SRC_W.
  - sy = (DrawY >> SCALE_SHIFT) + act_scroll_y; if sy >= SRC_H, subtract SRC_H.
  - rom_addr = sy*SRC_W + sx, truncated to ADDR_W.
  - in_range = DrawX < (SRC_W << SCALE_SHIFT) && DrawY < (SRC_H << SCALE_SHIFT).
- Stage B: ROM_LAT cycles, external. The block delays blank and in_range through a shift register of length 1+ROM_LAT.
- Stage C (output register):
  - Output is black when delayed blank = 0 or delayed in_range = 0.
  - Otherwise each channel = max(pal_c - fade_level, 0), 4-bit saturating subtract.
- Total latency from DrawX/DrawY/blank to RGB: ROM_LAT+2 cycles, with a constant one pixel per cycle and no stalls.
- Scroll shadow registers:
  - scroll_wen loads scroll_x_in/scroll_y_in at any time.
  - A write whose x >= SRC_W or y >= SRC_H is dropped entirely; neither axis updates.
- Active scroll registers copy the shadow only on frame_start, so there is no tearing mid-frame.
  - If scroll_wen and frame_start coincide and the write is legal, the active registers take the new value in the same cycle (write-through).
- Fade engine, on frame_start with fade_en=1:
  - fade_dir=1: fade_level increments, saturating at 15.
  - fade_dir=0: fade_level decrements, saturating at 0.
  - With fade_en=0 the level holds.
  - fade_level applies from the next pixel entering Stage C.
- Reset mid-frame: all pipeline contents are discarded and outputs are black on the next edge. Valid pixels resume ROM_LAT+2 cycles after reset deasserts.
- Wrap boundary: SRC_W=320, act_scroll_x=319, DrawX=2 (SHIFT=1) gives sx = 1+319 = 320, which wraps to 0.

Test Plan:
- Reset, scroll=0, SHIFT=1, ROM_LAT=1; drive DrawX=100, DrawY=50, blank=1 -> rom_addr=25*320+50=8050 one cycle later; RGB equals the palette colour of rom_q exactly 3 cycles after the input.
- Write scroll_x=300 mid-frame -> rom_addr unchanged until frame_start; after the pulse, DrawX=100, DrawY=0 -> sx=350-320=30, rom_addr=30.
- scroll_wen with scroll_x_in=320, scroll_y_in=5 -> both shadows hold their previous values; after frame_start the active scroll is unchanged.
- fade_en=1, fade_dir=1, 20 frame_start pulses, palette red=9 -> fade_level reads 1..15 and saturates; red output 8,7,…,0 and stays 0; then fade_dir=0 for 3 pulses -> level 12, red still 0.
- blank=0 pulse, or DrawX=639 with SRC_W=256, SHIFT=1 -> RGB=0 on exactly the matching output cycle; neighbouring pixels unaffected.
- Assert reset during active video with a non-zero pipeline -> RGB=0 next cycle; fade_level=0; active scroll=0; first valid colour 3 cycles after release.
